regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32×32 register file between two writeback requesters: A is ALU writeback and B is memory-load writeback. Arbitration is round-robin. The block registers the winning write onto the register file's `RegWrite` / `Write_Register` / `Write_Data` inputs. It also keeps a per-register pending-write scoreboard, fed by the issue stage, and raises `stall` when an instruction reads a register that still has an uncommitted write. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/regfile_write_arbiter.sv | 76 +++++++
 tb/tb_regfile_write_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and requester identifiers for the register-file write path.
package regfile_pkg;
    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters; stalls readers of registers with uncommitted writes.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              dec_en,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              iss_ready,
    output logic              stall
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_cnt
            if (i == 0) begin : g_zero
                assign cnt[i] = '0;
            end else begin : g_reg
                logic             inc, dec;
                logic [CNT_W-1:0] c;
                assign inc = inc_en && (inc_addr == ADDR_W'(i));
                assign dec = dec_en && (dec_addr == ADDR_W'(i));
                // A same-edge issue and commit cancel; otherwise clamp at both ends.
                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N)
                        c <= '0;
                    else if (inc && !dec && c != CNT_MAX)
                        c <= c + 1'b1;
                    else if (dec && !inc && c != '0)
                        c <= c - 1'b1;
                end
                assign cnt[i] = c;
            end
        end
    endgenerate

    assign iss_ready = (cnt[inc_addr] != CNT_MAX) || (inc_addr == '0);
    assign stall     = (cnt[rd_addr1] != '0) || (cnt[rd_addr2] != '0);
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter between ALU and load writeback onto the single register-file write port.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_Register,
    output logic [DATA_W-1:0] Write_Data
);
    req_id_t           prio;
    logic              a_acc, b_acc, acc, commit;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    // Readiness depends only on the other side's valid, so at most one side can be accepted.
    assign a_ready  = !(b_valid && prio == REQ_B);
    assign b_ready  = !(a_valid && prio == REQ_A);
    assign a_acc    = a_valid && a_ready;
    assign b_acc    = b_valid && b_ready;
    assign acc      = a_acc || b_acc;
    assign acc_addr = a_acc ? a_addr : b_addr;
    assign acc_data = a_acc ? a_data : b_data;
    assign commit   = acc && (acc_addr != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio           <= REQ_A;
            RegWrite       <= 1'b0;
            Write_Register <= '0;
            Write_Data     <= '0;
        end else begin
            if (a_acc)
                prio <= REQ_B;
            else if (b_acc)
                prio <= REQ_A;
            RegWrite <= commit;
            // r0 writes are consumed but leave the port contents untouched.
            if (commit) begin
                Write_Register <= acc_addr;
                Write_Data     <= acc_data;
            end
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_sb (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .inc_en   (iss_valid && iss_ready),
        .inc_addr (iss_addr),
        .dec_en   (RegWrite),
        .dec_addr (Write_Register),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .iss_ready(iss_ready),
        .stall    (stall)
    );
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the write arbiter against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int DW = 32, AW = 5, CW = 2, NR = 32, MAXC = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          a_valid, a_ready, b_valid, b_ready, iss_valid, iss_ready, stall;
    logic [AW-1:0] a_addr, b_addr, iss_addr, rd_addr1, rd_addr2, Write_Register;
    logic [DW-1:0] a_data, b_data, Write_Data;
    logic          RegWrite;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .stall(stall),
        .RegWrite(RegWrite), .Write_Register(Write_Register), .Write_Data(Write_Data)
    );

    always #5 CLK = ~CLK;

    // Model state: pending counts, whose turn it is on a tie, and the port contents.
    int            cnt_m [NR];
    bit            turn_b;
    logic          rw_m;
    logic [AW-1:0] wr_m;
    logic [DW-1:0] wd_m;
    bit            a_go, b_go;
    int            compared = 0, mismatched = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (cnt_m[i]) cnt_m[i] = 0;
        turn_b = 1'b0;
        rw_m = 1'b0; wr_m = '0; wd_m = '0;
    endtask

    task automatic check_comb();
        chk("a_ready", a_ready, !(b_valid && turn_b));
        chk("b_ready", b_ready, !(a_valid && !turn_b));
        chk("stall", stall, (cnt_m[rd_addr1] != 0) || (cnt_m[rd_addr2] != 0));
        chk("iss_ready", iss_ready, (iss_addr == 0) || (cnt_m[iss_addr] != MAXC));
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the model and check the port.
    task automatic cycle();
        bit inc, dec;
        int ia, da;
        @(negedge CLK);
        check_comb();
        a_go = a_valid && (!b_valid || !turn_b);
        b_go = b_valid && !a_go;
        ia   = int'(iss_addr);
        da   = int'(wr_m);
        inc  = iss_valid && ia != 0 && cnt_m[ia] != MAXC;
        dec  = rw_m;
        @(posedge CLK);
        #1;
        if (inc && dec && ia == da) begin
        end else begin
            if (inc) cnt_m[ia]++;
            if (dec && cnt_m[da] > 0) cnt_m[da]--;
        end
        if (a_go) turn_b = 1'b1;
        else if (b_go) turn_b = 1'b0;
        rw_m = 1'b0;
        if (a_go && a_addr != 0) begin rw_m = 1'b1; wr_m = a_addr; wd_m = a_data; end
        if (b_go && b_addr != 0) begin rw_m = 1'b1; wr_m = b_addr; wd_m = b_data; end
        chk("RegWrite", RegWrite, rw_m);
        chk("Write_Register", Write_Register, wr_m);
        chk("Write_Data", Write_Data, wd_m);
    endtask

    initial begin
        logic [AW-1:0] order [4];
        order[0] = 5'd1; order[1] = 5'd2; order[2] = 5'd1; order[3] = 5'd2;

        // Reset held with both requesters valid.
        RST_N = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        iss_valid = 1'b0; iss_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        model_reset();
        #2;
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_Write_Register", Write_Register, 5'd0);
        chk("rst_Write_Data", Write_Data, 32'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_b_ready", b_ready, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_RegWrite_held", RegWrite, 1'b0);
        RST_N = 1'b1;

        // Contention: strict alternation starting with A.
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("order", Write_Register, order[i]);
        end

        // Single A write (turn now A after the B grant).
        b_valid = 1'b0;
        a_addr = 5'd5; a_data = 32'hDEADBEEF;
        cycle();
        chk("single_RegWrite", RegWrite, 1'b1);
        chk("single_addr", Write_Register, 5'd5);
        chk("single_data", Write_Data, 32'hDEADBEEF);
        a_valid = 1'b0;
        cycle();
        chk("single_RegWrite_drop", RegWrite, 1'b0);

        // B writes r0: consumed, no commit, turn flips back to A.
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        #1 chk("r0_b_ready", b_ready, 1'b1);
        cycle();
        chk("r0_RegWrite", RegWrite, 1'b0);
        chk("r0_hold_data", Write_Data, 32'hDEADBEEF);
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9;
        #1 chk("r0_turn_a", a_ready, 1'b1);
        chk("r0_turn_b", b_ready, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();

        // Scoreboard: issue r7, then commit r7.
        iss_valid = 1'b1; iss_addr = 5'd7; rd_addr1 = 5'd7;
        cycle();
        iss_valid = 1'b0;
        #1 chk("sb_stall_set", stall, 1'b1);
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1234;
        cycle();
        a_valid = 1'b0;
        #1 chk("sb_stall_during_commit", stall, 1'b1);
        chk("sb_commit_data", Write_Data, 32'h1234);
        cycle();
        #1 chk("sb_stall_clear", stall, 1'b0);

        // Saturation on r3, then overlapping issue and commit.
        iss_valid = 1'b1; iss_addr = 5'd3; rd_addr1 = 5'd3; rd_addr2 = 5'd0;
        for (int i = 0; i < 3; i++) cycle();
        #1 chk("sat_iss_ready", iss_ready, 1'b0);
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        cycle();
        cycle();
        a_valid = 1'b0;
        cycle();
        #1 chk("simul_keeps_count", iss_ready, 1'b1);
        iss_valid = 1'b0;
        cycle();

        // Randomized traffic with an asynchronous reset in the middle.
        a_go = 1'b0; b_go = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || a_go) begin
                a_valid = 1'($urandom % 2); a_addr = AW'($urandom % 8); a_data = $urandom;
            end
            if (!b_valid || b_go) begin
                b_valid = 1'($urandom % 2); b_addr = AW'($urandom % 8); b_data = $urandom;
            end
            iss_valid = ($urandom % 3) == 0;
            iss_addr  = AW'($urandom % 8);
            rd_addr1  = AW'($urandom % 8);
            rd_addr2  = AW'($urandom % 8);
            if (n == 200) begin
                #1 RST_N = 1'b0;
                #1;
                model_reset();
                chk("async_rst_stall", stall, 1'b0);
                chk("async_rst_RegWrite", RegWrite, 1'b0);
                chk("async_rst_Write_Register", Write_Register, 5'd0);
                check_comb();
                #1 RST_N = 1'b1;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
